// File: rtl/raizing_pcm_router.sv
`timescale 1ns/1ps
// raizing_pcm_router
// Routes byte reads from the PCM sound chip to one of NBANK SDRAM banks.
// A one-entry byte cache answers repeated reads of the same address without
// touching the banks. Out-of-range reads return 8'h00. A fetch that never
// sees an accepted ok from its bank returns 8'hFF and latches tmo_err.
module raizing_pcm_router #(
   parameter int NBANK   = 3,
   parameter int BANK_AW = 22,
   parameter int REQ_AW  = 24,
   parameter int TMO     = 1023
) (
   input  logic                 CLK96,
   input  logic                 RESET96,
   input  logic                 req_rd,
   input  logic [REQ_AW-1:0]    req_addr,
   output logic [7:0]           req_dout,
   output logic                 req_valid,
   output logic [NBANK-1:0]     bank_cs,
   output logic [BANK_AW-1:0]   bank_addr,
   input  logic [8*NBANK-1:0]   bank_dout,
   input  logic [NBANK-1:0]     bank_ok,
   output logic                 busy,
   output logic                 tmo_err
);

   localparam int IDXW = REQ_AW - BANK_AW;
   localparam int CNTW = (TMO < 2) ? 1 : $clog2(TMO + 1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TMO - 1);
   localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(TMO);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state;
   logic [REQ_AW-1:0]   tag;
   logic [REQ_AW-1:0]   cache_tag;
   logic [7:0]          cache_data;
   logic                cache_valid;
   logic [CNTW-1:0]     tmo_cnt;

   logic [IDXW-1:0]     req_idx;
   logic                req_in_range;
   logic                req_hit;
   logic [NBANK-1:0]    req_onehot;
   logic                sel_ok;
   logic [7:0]          sel_data;
   logic                ok_accept;
   logic                tmo_hit;

   // Decode the incoming request: bank index, range check, cache hit and one-hot select
   always_comb begin
      req_idx      = req_addr[REQ_AW-1:BANK_AW];
      req_in_range = ({1'b0, req_idx} < (IDXW + 1)'(NBANK));
      req_hit      = cache_valid && (req_addr == cache_tag);
      req_onehot   = '0;
      for (int i = 0; i < NBANK; i++) begin
         req_onehot[i] = (req_idx == IDXW'(i));
      end
   end

   // Only the bank currently selected by bank_cs can supply ok and data
   always_comb begin
      sel_ok   = |(bank_ok & bank_cs);
      sel_data = 8'h00;
      for (int i = 0; i < NBANK; i++) begin
         if (bank_cs[i]) begin
            sel_data = sel_data | bank_dout[8*i +: 8];
         end
      end
      ok_accept = sel_ok && (tmo_cnt != '0);
      tmo_hit   = (tmo_cnt == CNT_LAST);
   end

   // Request FSM with registered outputs, cache and saturating timeout counter
   always_ff @(posedge CLK96 or posedge RESET96) begin
      if (RESET96) begin
         state       <= IDLE;
         tag         <= '0;
         cache_tag   <= '0;
         cache_data  <= 8'h00;
         cache_valid <= 1'b0;
         tmo_cnt     <= '0;
         req_dout    <= 8'h00;
         req_valid   <= 1'b0;
         bank_cs     <= '0;
         bank_addr   <= '0;
         busy        <= 1'b0;
         tmo_err     <= 1'b0;
      end else begin
         req_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_rd) begin
                  tag       <= req_addr;
                  bank_addr <= req_addr[BANK_AW-1:0];
                  busy      <= 1'b1;
                  if (!req_in_range) begin
                     state     <= DONE;
                     req_dout  <= 8'h00;
                     req_valid <= 1'b1;
                  end else if (req_hit) begin
                     state     <= DONE;
                     req_dout  <= cache_data;
                     req_valid <= 1'b1;
                  end else begin
                     state   <= FETCH;
                     bank_cs <= req_onehot;
                     tmo_cnt <= '0;
                  end
               end
            end
            FETCH: begin
               if (tmo_cnt != CNT_MAX) begin
                  tmo_cnt <= tmo_cnt + CNTW'(1);
               end
               if (ok_accept) begin
                  cache_data  <= sel_data;
                  cache_tag   <= tag;
                  cache_valid <= 1'b1;
                  req_dout    <= sel_data;
                  req_valid   <= 1'b1;
                  bank_cs     <= '0;
                  state       <= DONE;
               end else if (tmo_hit) begin
                  cache_valid <= 1'b0;
                  tmo_err     <= 1'b1;
                  req_dout    <= 8'hFF;
                  req_valid   <= 1'b1;
                  bank_cs     <= '0;
                  state       <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               bank_cs <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_raizing_pcm_router.sv
`timescale 1ns/1ps
// tb_raizing_pcm_router
// Drives directed and random read requests and checks the router each cycle
// against a request-level model of the cache, banks and timeout.
module tb_raizing_pcm_router;

   localparam int NB    = 3;
   localparam int TMO_T = 15;

   logic          CLK96 = 1'b0;
   logic          RESET96;
   logic          req_rd;
   logic [23:0]   req_addr;
   logic [7:0]    req_dout;
   logic          req_valid;
   logic [2:0]    bank_cs;
   logic [21:0]   bank_addr;
   logic [23:0]   bank_dout;
   logic [2:0]    bank_ok;
   logic          busy;
   logic          tmo_err;

   int testsRun    = 0;
   int testsFailed = 0;
   bit checkEn     = 1'b0;

   // Expected outputs for the current cycle
   logic [2:0]  expCs       = 3'b000;
   logic        expValid    = 1'b0;
   logic        expBusy     = 1'b0;
   logic        expTmo      = 1'b0;
   logic [7:0]  expDout     = 8'h00;
   logic [21:0] expBankAddr = 22'h0;

   // Model of the one-entry cache
   bit          mValid = 1'b0;
   logic [23:0] mTag   = 24'h0;
   logic [7:0]  mData  = 8'h00;

   raizing_pcm_router #(
      .NBANK(NB), .BANK_AW(22), .REQ_AW(24), .TMO(TMO_T)
   ) dut (
      .CLK96(CLK96), .RESET96(RESET96),
      .req_rd(req_rd), .req_addr(req_addr),
      .req_dout(req_dout), .req_valid(req_valid),
      .bank_cs(bank_cs), .bank_addr(bank_addr),
      .bank_dout(bank_dout), .bank_ok(bank_ok),
      .busy(busy), .tmo_err(tmo_err)
   );

   // 100 MHz-style free-running clock
   always #5 CLK96 = ~CLK96;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every output against the model on the falling edge
   always @(negedge CLK96) begin
      if (checkEn) begin
         checkOutput("bank_cs",   32'(bank_cs),   32'(expCs));
         checkOutput("req_valid", 32'(req_valid), 32'(expValid));
         checkOutput("busy",      32'(busy),      32'(expBusy));
         checkOutput("tmo_err",   32'(tmo_err),   32'(expTmo));
         checkOutput("req_dout",  32'(req_dout),  32'(expDout));
         checkOutput("bank_addr", 32'(bank_addr), 32'(expBankAddr));
      end
   end

   // One complete request: classify it with the model, drive the banks, then return to idle
   task automatic applyStimulus(input logic [23:0] addr, input int okCycle, input logic [7:0] data,
                                input bit staleOk, input bit dropRd,
                                output int lat, output logic [2:0] obsCs, output logic [7:0] obsDout);
      int         idx;
      bit         isMiss;
      bit         timedOut;
      int         fetchEnd;
      int         doneCycle;
      logic [7:0] result;
      logic [2:0] okv;
      idx      = int'(addr[23:22]);
      lat      = 0;
      obsCs    = 3'b000;
      obsDout  = 8'h00;
      isMiss   = 1'b0;
      timedOut = 1'b0;
      fetchEnd = 0;
      if (idx >= NB) begin
         doneCycle = 1;
         result    = 8'h00;
      end else if (mValid && addr == mTag) begin
         doneCycle = 1;
         result    = mData;
      end else begin
         isMiss = 1'b1;
         for (int c = 2; c <= TMO_T; c++) begin
            if (fetchEnd == 0 && (staleOk || c == okCycle)) fetchEnd = c;
         end
         if (fetchEnd == 0) begin
            fetchEnd = TMO_T;
            timedOut = 1'b1;
            result   = 8'hFF;
         end else begin
            result = data;
         end
         doneCycle = fetchEnd + 1;
      end

      req_rd    = 1'b1;
      req_addr  = addr;
      bank_dout = 24'($urandom);
      okv       = 3'($urandom);
      if (idx < NB) begin
         okv[idx] = isMiss && staleOk;
         if (isMiss) bank_dout[8*idx +: 8] = data;
      end
      bank_ok = okv;

      for (int c = 1; c <= doneCycle; c++) begin
         @(posedge CLK96); #1;
         if (req_valid && lat == 0) lat = c;
         obsCs = obsCs | bank_cs;
         if (c == 1) expBankAddr = addr[21:0];
         if (c < doneCycle) begin
            expCs     = 3'(1 << idx);
            expValid  = 1'b0;
            expBusy   = 1'b1;
            bank_dout = 24'($urandom);
            bank_dout[8*idx +: 8] = data;
            okv      = 3'($urandom);
            okv[idx] = staleOk || (c == okCycle);
            bank_ok  = okv;
            if (dropRd && c == 1) req_rd = 1'b0;
         end else begin
            expCs    = 3'b000;
            expValid = 1'b1;
            expBusy  = 1'b1;
            expDout  = result;
            obsDout  = req_dout;
            if (isMiss) begin
               if (timedOut) begin
                  mValid = 1'b0;
                  expTmo = 1'b1;
               end else begin
                  mValid = 1'b1;
                  mTag   = addr;
                  mData  = data;
               end
            end
            req_rd  = 1'b0;
            bank_ok = 3'b000;
         end
      end
      @(posedge CLK96); #1;
      expValid = 1'b0;
      expBusy  = 1'b0;
      expCs    = 3'b000;
   endtask

   logic [23:0] pool [6] = '{24'h400010, 24'h000020, 24'h000040, 24'h800100, 24'hC00000, 24'hFF1234};

   initial begin
      int         lat;
      logic [2:0] cs;
      logic [7:0] dout;
      logic [23:0] a;

      RESET96   = 1'b1;
      req_rd    = 1'b0;
      req_addr  = 24'h0;
      bank_dout = 24'h0;
      bank_ok   = 3'b000;
      repeat (3) @(posedge CLK96);
      #1;
      checkOutput("reset_dout",  32'(req_dout), 32'h00);
      checkOutput("reset_busy",  32'(busy),     32'h0);
      checkOutput("reset_cs",    32'(bank_cs),  32'h0);
      RESET96 = 1'b0;
      checkEn = 1'b1;
      @(posedge CLK96); #1;

      // Miss with ok on FETCH cycle 3
      applyStimulus(24'h400010, 3, 8'h5A, 1'b0, 1'b0, lat, cs, dout);
      checkOutput("miss_lat",  32'(lat),  32'd4);
      checkOutput("miss_cs",   32'(cs),   32'b010);
      checkOutput("miss_dout", 32'(dout), 32'h5A);
      checkOutput("miss_addr", 32'(bank_addr), 32'h000010);

      // Hit on the same address
      applyStimulus(24'h400010, 3, 8'h11, 1'b0, 1'b0, lat, cs, dout);
      checkOutput("hit_lat",  32'(lat),  32'd1);
      checkOutput("hit_cs",   32'(cs),   32'b000);
      checkOutput("hit_dout", 32'(dout), 32'h5A);

      // Out-of-range then the cached address again
      applyStimulus(24'hC00000, 3, 8'h22, 1'b0, 1'b0, lat, cs, dout);
      checkOutput("oor_lat",  32'(lat),  32'd1);
      checkOutput("oor_cs",   32'(cs),   32'b000);
      checkOutput("oor_dout", 32'(dout), 32'h00);
      applyStimulus(24'h400010, 3, 8'h33, 1'b0, 1'b0, lat, cs, dout);
      checkOutput("oor_hit_lat",  32'(lat),  32'd1);
      checkOutput("oor_hit_dout", 32'(dout), 32'h5A);

      // Stale ok held from before acceptance
      applyStimulus(24'h000020, 0, 8'h3C, 1'b1, 1'b0, lat, cs, dout);
      checkOutput("stale_lat",  32'(lat),  32'd3);
      checkOutput("stale_cs",   32'(cs),   32'b001);
      checkOutput("stale_dout", 32'(dout), 32'h3C);

      // Timeout, then the same address must refetch
      applyStimulus(24'h000040, 0, 8'h44, 1'b0, 1'b0, lat, cs, dout);
      checkOutput("tmo_lat",  32'(lat),     32'd16);
      checkOutput("tmo_dout", 32'(dout),    32'hFF);
      checkOutput("tmo_flag", 32'(tmo_err), 32'h1);
      applyStimulus(24'h000040, 2, 8'h77, 1'b0, 1'b0, lat, cs, dout);
      checkOutput("refetch_cs",   32'(cs),   32'b001);
      checkOutput("refetch_lat",  32'(lat),  32'd3);
      checkOutput("refetch_dout", 32'(dout), 32'h77);

      // Reset in the middle of a fetch
      req_rd   = 1'b1;
      req_addr = 24'h800080;
      bank_ok  = 3'b000;
      @(posedge CLK96); #1;
      expBankAddr = 22'h000080;
      expCs       = 3'b100;
      expBusy     = 1'b1;
      @(posedge CLK96); #1;
      checkOutput("rst_fetch_cs", 32'(bank_cs), 32'b100);
      #2;
      checkEn = 1'b0;
      RESET96 = 1'b1;
      #1;
      checkOutput("rst_async_cs",   32'(bank_cs), 32'b000);
      checkOutput("rst_async_busy", 32'(busy),    32'h0);
      req_rd = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK96); #1;
         checkOutput("rst_valid", 32'(req_valid), 32'h0);
         checkOutput("rst_dout",  32'(req_dout),  32'h00);
      end
      RESET96     = 1'b0;
      mValid      = 1'b0;
      expTmo      = 1'b0;
      expDout     = 8'h00;
      expBankAddr = 22'h0;
      expCs       = 3'b000;
      expValid    = 1'b0;
      expBusy     = 1'b0;
      checkEn     = 1'b1;
      @(posedge CLK96); #1;
      applyStimulus(24'h400010, 2, 8'hA5, 1'b0, 1'b0, lat, cs, dout);
      checkOutput("post_rst_cs",   32'(cs),   32'b010);
      checkOutput("post_rst_dout", 32'(dout), 32'hA5);

      // Random traffic, back-to-back and with idle gaps
      for (int n = 0; n < 250; n++) begin
         int pick;
         pick = $urandom_range(0, 7);
         if (pick < 6) a = pool[pick];
         else a = 24'($urandom);
         applyStimulus(a, $urandom_range(0, TMO_T + 2), 8'($urandom),
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                       lat, cs, dout);
         if ($urandom_range(0, 3) == 0) begin
            int gap;
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
               bank_ok   = 3'($urandom);
               bank_dout = 24'($urandom);
               @(posedge CLK96); #1;
            end
            bank_ok = 3'b000;
         end
      end

      checkEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Guard against a stuck run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/raizing_pcm_router.md
RAIZING_PCM_ROUTER -- requirements
Module: raizing_pcm_router

Interface
REQ-001 Parameter NBANK, default 3, number of PCM SDRAM banks (legal 1..4).
REQ-002 Parameter BANK_AW, default 22, byte-address width of one bank.
REQ-003 Parameter REQ_AW, default 24, requester byte-address width; REQ_AW SHALL be at least BANK_AW+2.
REQ-004 Parameter TMO, default 1023, fetch timeout in CLK96 cycles.
REQ-005 CLK96  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-006 RESET96  in  1  reset, asynchronous, active-high.
REQ-007 req_rd  in  1  read request level from the PCM chip; held high until req_valid.
REQ-008 req_addr  in  REQ_AW  requested byte address; stable while req_rd is high.
REQ-009 req_dout  out  8  returned byte; valid when req_valid is high.
REQ-010 req_valid  out  1  single-cycle data-valid pulse.
REQ-011 bank_cs  out  NBANK  one-hot bank chip-select.
REQ-012 bank_addr  out  BANK_AW  registered in-bank address, shared by all banks.
REQ-013 bank_dout  in  8*NBANK  bank data; bank i occupies bits [8i+7:8i].
REQ-014 bank_ok  in  NBANK  per-bank data-ready flag.
REQ-015 busy  out  1  high whenever the FSM is not in IDLE.
REQ-016 tmo_err  out  1  sticky flag, set on any fetch timeout.

Function
REQ-017 Bank index SHALL be req_addr[REQ_AW-1:BANK_AW]; an index of NBANK or more SHALL be out-of-range.
REQ-018 The FSM SHALL have states IDLE, FETCH and DONE.
REQ-019 A request SHALL only be accepted in IDLE on a cycle where req_rd=1.
REQ-020 On acceptance, the block SHALL register req_addr into the tag register and the in-bank bits into bank_addr.
REQ-021 Cache hit: if the cache is valid and req_addr equals the cached tag, the FSM SHALL go IDLE->DONE, assert no bank_cs, and present the cached byte.
REQ-022 Out-of-range: the FSM SHALL go IDLE->DONE with req_dout=8'h00, assert no bank_cs, and leave the cache unchanged.
REQ-023 Miss: the FSM SHALL go IDLE->FETCH and assert bank_cs[idx] from the next cycle until exit.
REQ-024 In FETCH, bank_ok[idx] SHALL be ignored on the first FETCH cycle (stale ok).
REQ-025 From the second FETCH cycle, when bank_ok[idx]=1, the block SHALL capture bank_dout[idx] into the cache data, set the tag and cache-valid, drop bank_cs and go to DONE.
REQ-026 Timeout: if TMO cycles elapse in FETCH without an accepted ok, the block SHALL go to DONE with req_dout=8'hFF, set tmo_err, and invalidate the cache.
REQ-027 In DONE, req_valid SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-028 req_dout SHALL hold its last value outside DONE.
REQ-029 Latency from acceptance to req_valid:
  - 1 cycle for a hit or an out-of-range request;
  - n+1 cycles for a miss whose accepted ok arrives on FETCH cycle n (n>=2).
REQ-030 A request accepted in the cycle immediately after DONE SHALL be handled normally (back-to-back support).
REQ-031 If req_rd falls mid-FETCH, the fetch SHALL still complete and pulse req_valid, and the requester SHALL ignore that pulse.
REQ-032 bank_ok on a non-selected bank SHALL be ignored.
REQ-033 At most one bank_cs bit SHALL be high at any time.
REQ-034 The timeout counter SHALL be TMO-width-safe, saturating, and cleared on each FETCH entry.

Reset
REQ-035 While RESET96 is high, the block SHALL be in IDLE with:
  - bank_cs=0, bank_addr=0;
  - req_dout=8'h00, req_valid=0, busy=0, tmo_err=0;
  - cache invalid, tag=0, timeout counter=0.
REQ-036 Reset asserted mid-FETCH SHALL drop bank_cs asynchronously.
REQ-037 After reset deasserts, the first request SHALL always be a miss or out-of-range.

Verification
REQ-038 Miss: NBANK=3; req_addr=24'h400010; bank_ok[1] high on FETCH cycle 3 with byte 8'h5A -> bank_cs=3'b010, bank_addr=22'h000010, req_dout=8'h5A, req_valid pulses 4 cycles after acceptance.
REQ-039 Hit: repeat the same address -> no bank_cs activity, req_valid 1 cycle after acceptance, req_dout=8'h5A.
REQ-040 Out-of-range: req_addr=24'hC00000 -> req_dout=8'h00 after 1 cycle, bank_cs stays 0, and a following 24'h400010 request still hits.
REQ-041 Stale ok: bank_ok[0] held high from before acceptance with req_addr=24'h000020 -> ok ignored on FETCH cycle 1, data accepted on cycle 2, req_valid on cycle 3.
REQ-042 Timeout: TMO=15, bank_ok never asserted -> req_dout=8'hFF after 16 cycles, tmo_err=1, and the next same-address request refetches.
REQ-043 Reset: RESET96 pulsed during FETCH -> bank_cs=0 immediately, no req_valid, and the next request misses.
